// File: rtl/id_stage.sv
// id_stage: instruction decode stage.
// Holds a 64 x 32-bit register file with write-through bypass and decodes the
// opcode into ID/EX control fields. It also detects load-use hazards against
// the instruction in EX and inserts a single-cycle bubble for them.
module id_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_in,
    input  logic        wb_en,
    input  logic [5:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        ex_memread_in,
    input  logic [5:0]  ex_rd_in,
    output logic [5:0]  rd_out,
    output logic [31:0] rs_out,
    output logic [31:0] rt_out,
    output logic [31:0] signExtend_out,
    output logic [3:0]  ALUOP_out,
    output logic        regwrite_out,
    output logic        memread_out,
    output logic        memwrite_out,
    output logic        stall_out
);

    typedef enum logic [3:0] {
        OP_NOP  = 4'b0000,
        OP_ST   = 4'b0011,
        OP_ADD  = 4'b0100,
        OP_INC  = 4'b0101,
        OP_NEG  = 4'b0110,
        OP_SUB  = 4'b0111,
        OP_J    = 4'b1000,
        OP_BRZ  = 4'b1001,
        OP_JM   = 4'b1010,
        OP_BRN  = 4'b1011,
        OP_LD   = 4'b1110,
        OP_SVPC = 4'b1111
    } opcode_e;

    logic [31:0] r_rf [64];
    logic        r_stalled;

    logic [3:0]  w_opcode;
    logic [5:0]  w_rs_idx;
    logic [5:0]  w_rt_idx;
    logic [3:0]  w_aluop;
    logic        w_regwrite;
    logic        w_memread;
    logic        w_memwrite;
    logic        w_rs_used;
    logic        w_rt_used;
    logic        w_hazard;
    logic        w_bubble;

    assign w_opcode = instr_in[31:28];
    assign w_rs_idx = instr_in[21:16];
    assign w_rt_idx = instr_in[15:10];

    // One register per entry; entry 0 is an ordinary writable register.
    // Reset wins over a write-back arriving in the same cycle.
    genvar gi;
    generate
        for (gi = 0; gi < 64; gi++) begin : g_rf
            // Clear on reset, otherwise capture write-back addressed to this entry
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_rf[gi] <= 32'd0;
                end else if (wb_en && (wb_rd == 6'(gi))) begin
                    r_rf[gi] <= wb_data;
                end
            end
        end
    endgenerate

    // Remember whether this cycle stalled so the same instruction cannot stall twice in a row
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stalled <= 1'b0;
        end else begin
            r_stalled <= stall_out;
        end
    end

    // Combinational operand reads with write-through bypass from the write-back port
    always_comb begin
        rs_out = r_rf[w_rs_idx];
        rt_out = r_rf[w_rt_idx];
        if (wb_en && (wb_rd == w_rs_idx)) begin
            rs_out = wb_data;
        end
        if (wb_en && (wb_rd == w_rt_idx)) begin
            rt_out = wb_data;
        end
    end

    // Opcode decode; anything outside the map behaves exactly like NOP
    always_comb begin
        w_aluop    = 4'b0000;
        w_regwrite = 1'b0;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        w_rs_used  = 1'b0;
        w_rt_used  = 1'b0;
        case (w_opcode)
            OP_SVPC: begin
                w_aluop    = w_opcode;
                w_regwrite = 1'b1;
            end
            OP_LD: begin
                w_aluop    = w_opcode;
                w_regwrite = 1'b1;
                w_memread  = 1'b1;
                w_rs_used  = 1'b1;
            end
            OP_ST: begin
                w_aluop    = w_opcode;
                w_memwrite = 1'b1;
                w_rs_used  = 1'b1;
                w_rt_used  = 1'b1;
            end
            OP_ADD, OP_SUB: begin
                w_aluop    = w_opcode;
                w_regwrite = 1'b1;
                w_rs_used  = 1'b1;
                w_rt_used  = 1'b1;
            end
            OP_INC, OP_NEG: begin
                w_aluop    = w_opcode;
                w_regwrite = 1'b1;
                w_rs_used  = 1'b1;
            end
            OP_J, OP_BRZ, OP_JM, OP_BRN: begin
                w_aluop    = w_opcode;
                w_rs_used  = 1'b1;
            end
            default: begin
                w_aluop    = 4'b0000;
            end
        endcase
    end

    // Load-use hazard: EX is loading into a register this instruction actually reads
    assign w_hazard = ex_memread_in &&
                      ((w_rs_used && (ex_rd_in == w_rs_idx)) ||
                       (w_rt_used && (ex_rd_in == w_rt_idx)));

    assign stall_out = rst_n && !r_stalled && w_hazard;

    // Controls are squashed to a bubble while stalling and throughout reset
    assign w_bubble = stall_out || !rst_n;

    // Drive the ID/EX fields; data fields always follow instr_in
    always_comb begin
        rd_out         = instr_in[27:22];
        signExtend_out = {{10{instr_in[21]}}, instr_in[21:0]};
        ALUOP_out      = w_bubble ? 4'b0000 : w_aluop;
        regwrite_out   = w_bubble ? 1'b0 : w_regwrite;
        memread_out    = w_bubble ? 1'b0 : w_memread;
        memwrite_out   = w_bubble ? 1'b0 : w_memwrite;
    end

endmodule
